ocm_capture_ram: RTL
====================

Name: ocm_capture_ram

Overview:
- Parametrised successor to the single-port Avalon on-chip memory used by the Rx simulation path.
- Port A is an Avalon-MM slave for the Nios/host side, with byte-enables, clock enable and an optional output register.
- Port B is an internal streaming capture port. A capture FSM fills the RAM from Rx samples in either one-shot or ring-with-trigger mode, so software can read back waveform snapshots.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- ADDR_W, 10, word address width; DEPTH = 2**ADDR_W.
- OUT_REG, 0, 0 gives 1-cycle read latency; 1 adds an output register for 2-cycle latency.
- INIT_FILE, "onchip_mem.hex", simulation/synthesis init image.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-low reset.
- address  in  ADDR_W  Avalon word address.
- byteenable  in  DATA_W/8  Avalon byte lanes.
- chipselect  in  1  Avalon select.
- read  in  1  Avalon read.
- write  in  1  Avalon write.
- writedata  in  DATA_W  Avalon write data.
- readdata  out  DATA_W  Avalon read data.
- readdatavalid  out  1  read data qualifier.
- clken  in  1  Avalon-port clock enable.
- reset_req  in  1  blocks the Avalon port, same as clken low.
- cap_arm  in  1  one-cycle pulse; starts or restarts a capture.
- cap_abort  in  1  one-cycle pulse; returns the FSM to IDLE.
- cap_mode  in  1  0 = ONESHOT, 1 = RING; sampled on arm.
- cap_post  in  ADDR_W  post-trigger sample count; sampled on arm.
- cap_trigger  in  1  trigger pulse, used in RING mode only.
- cap_valid  in  1  sample strobe.
- cap_data  in  DATA_W  sample word.
- cap_busy  out  1  FSM is in FILL or POST.
- cap_done  out  1  FSM is in DONE.
- cap_wr_ptr  out  ADDR_W  next capture address.
- cap_trig_addr  out  ADDR_W  address at which the trigger was latched.

Behaviour:
- Reset (reset==0 at a clk edge) clears the following: readdata=0, readdatavalid=0, cap_busy=0, cap_done=0, cap_wr_ptr=0, cap_trig_addr=0, FSM=IDLE, output pipeline. RAM contents are not cleared.
- Avalon port is enabled when en = clken & ~reset_req.
  - Writes: en & chipselect & write updates only the lanes with byteenable set.
  - Reads: en & chipselect & read returns readdata 1 cycle later (OUT_REG=0) or 2 cycles later (OUT_REG=1). readdatavalid pulses high for 1 cycle with the data.
  - When en is low, the read pipeline freezes: readdata holds and readdatavalid is 0 while frozen; the pending read completes after en returns.
  - read and write asserted together is treated as a write only; no readdatavalid is produced.
- Read-during-write to the same address on the Avalon port returns the old data.
- Capture write is a full-word write to mem[cap_wr_ptr] on cap_valid, in the FILL or POST state only. It does not depend on clken.
- Collision: if an Avalon write and a capture write target the same address in the same cycle, the capture write wins. An Avalon read of that address returns the old data.
- FSM states: IDLE, FILL, POST, DONE.
  - IDLE/DONE to FILL: on cap_arm. This sets cap_wr_ptr=0 and latches the mode and a post counter rem=cap_post.
  - FILL to FILL: cap_arm restarts the capture (pointer reset to 0).
  - FILL, ONESHOT mode: each valid sample increments the pointer. The sample written at address DEPTH-1 moves the FSM to DONE; cap_wr_ptr wraps to 0.
  - FILL, RING mode: the pointer wraps modulo DEPTH with no stop. On cap_trigger, cap_trig_addr is latched with cap_wr_ptr (the value before any same-cycle increment) and the FSM moves to POST. A cap_valid in the same cycle as the trigger is written and does count toward rem.
  - POST: each valid sample decrements rem. When rem reaches 0, the FSM moves to DONE. If rem is already 0 when POST is entered, the FSM goes to DONE on the next cycle with no further writes.
  - cap_trigger is ignored in IDLE, POST, DONE, and in ONESHOT mode.
  - cap_abort in any state moves the FSM to IDLE; cap_wr_ptr holds its value. If abort and arm occur in the same cycle, abort wins.
  - Reset mid-capture: FSM returns to IDLE; written samples remain in RAM.
- Status outputs are registered and reflect the state after the clock edge.

Decomposition:
- ocm_pkg holds: cap_state_t enum (IDLE, FILL, POST, DONE), CAP_ONESHOT=1'b0, CAP_RING=1'b1.
- Sub-module ocm_capture_ctrl contains the FSM, pointer, rem counter and trig_addr latch. It outputs cap_we, cap_addr and the status signals.
- The top level holds the inferred true-dual-port RAM (byte-enable on port A), the read pipeline and collision muxing.

Test Plan:
- Avalon writes 0xA5A5A5A5 to addr 3, then writes with byteenable 4'b0010 and data 0x00FF0000 (lane 1 = 0x00), then reads addr 3. Expect 0xA5A500A5 after 1 cycle (OUT_REG=0) and after 2 cycles (OUT_REG=1), with a single readdatavalid pulse.
- Read issued, then clken=0 for 3 cycles. Expect readdatavalid held low and readdata unchanged; data is delivered on the first enabled cycle.
- ONESHOT arm, then 1024 valid samples with data=index. Expect cap_done after the 1024th sample, cap_wr_ptr=0, and mem[k]=k; extra samples are not written.
- RING arm, cap_post=4, 1500 samples, trigger at sample 1200. Expect cap_trig_addr=176, DONE after 4 more samples, and mem[179]=1203.
- Same-address collision: Avalon write 0x1 and capture write 0x2 to addr 5 in the same cycle. Expect mem[5]=0x2.
- cap_abort during POST, then reset during FILL. Expect IDLE both times, cap_busy=0, and earlier samples still readable.

Source files
------------

// File: rtl/ocm_pkg.sv
// ---------------------------------------------------------------------------
// ocm_pkg
// Shared types for the on-chip capture RAM:
//   cap_state_t  - capture FSM states (IDLE, FILL, POST, DONE)
//   CAP_ONESHOT  - cap_mode value: fill the RAM once, then stop
//   CAP_RING     - cap_mode value: wrap continuously until a trigger, then
//                  record a fixed number of post-trigger samples
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
package ocm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    POST = 2'd2,
    DONE = 2'd3
  } cap_state_t;

  localparam logic CAP_ONESHOT = 1'b0;
  localparam logic CAP_RING    = 1'b1;

endpackage

// File: rtl/ocm_capture_ctrl.sv
// ---------------------------------------------------------------------------
// ocm_capture_ctrl
// Capture sequencer for the streaming side (port B) of the capture RAM.
// Owns the FSM, the write pointer, the post-trigger countdown and the
// trigger address latch. It only decides where and when a sample is stored;
// the RAM itself lives in the parent.
//
// Ports:
//   clk, reset      clock, synchronous active-low reset
//   cap_arm         pulse: start/restart a capture (pointer back to 0)
//   cap_abort       pulse: back to IDLE, pointer holds (wins over cap_arm)
//   cap_mode        CAP_ONESHOT / CAP_RING, sampled on arm
//   cap_post        post-trigger sample count, sampled on arm
//   cap_trigger     trigger pulse, honoured in RING mode while filling
//   cap_valid       sample strobe
//   cap_we          full-word write strobe towards the RAM
//   cap_addr        address for that write
//   cap_busy        registered: FSM in FILL or POST
//   cap_done        registered: FSM in DONE
//   cap_wr_ptr      next capture address
//   cap_trig_addr   address that was current when the trigger arrived
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module ocm_capture_ctrl
  import ocm_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cap_arm,
  input  logic              cap_abort,
  input  logic              cap_mode,
  input  logic [ADDR_W-1:0] cap_post,
  input  logic              cap_trigger,
  input  logic              cap_valid,
  output logic              cap_we,
  output logic [ADDR_W-1:0] cap_addr,
  output logic              cap_busy,
  output logic              cap_done,
  output logic [ADDR_W-1:0] cap_wr_ptr,
  output logic [ADDR_W-1:0] cap_trig_addr
);

  localparam logic [ADDR_W-1:0] PTR_LAST = '1;
  localparam logic [ADDR_W-1:0] REM_ONE  = ADDR_W'(1);

  cap_state_t        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic [ADDR_W-1:0] trig_q, trig_d;
  logic              mode_q, mode_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      trig_q  <= '0;
      mode_q  <= CAP_ONESHOT;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      trig_q  <= trig_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    trig_d  = trig_q;
    mode_d  = mode_q;
    if (cap_abort) begin
      state_d = IDLE;
    end else if (cap_arm) begin
      state_d = FILL;
      ptr_d   = '0;
      rem_d   = cap_post;
      mode_d  = cap_mode;
    end else begin
      unique case (state_q)
        FILL: begin
          if (cap_valid) ptr_d = ptr_q + 1'b1;
          if (mode_q == CAP_ONESHOT) begin
            // The word stored at the last address completes the snapshot;
            // the pointer wraps back to 0 by itself.
            if (cap_valid && (ptr_q == PTR_LAST)) state_d = DONE;
          end else if (cap_trigger) begin
            // Latch the pre-increment pointer; a sample arriving with the
            // trigger is already part of the post-trigger window.
            trig_d  = ptr_q;
            state_d = POST;
            if (cap_valid && (rem_q != '0)) rem_d = rem_q - 1'b1;
          end
        end
        POST: begin
          if (rem_q == '0) begin
            state_d = DONE;
          end else if (cap_valid) begin
            ptr_d = ptr_q + 1'b1;
            rem_d = rem_q - 1'b1;
            if (rem_q == REM_ONE) state_d = DONE;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs: write strobe from the current state, status from the next one
  // so the registered flags describe the state after the edge.
  always_comb begin
    cap_we = 1'b0;
    if (cap_valid && !cap_abort && !cap_arm) begin
      if (state_q == FILL) cap_we = 1'b1;
      else if ((state_q == POST) && (rem_q != '0)) cap_we = 1'b1;
    end
    busy_d = (state_d == FILL) || (state_d == POST);
    done_d = (state_d == DONE);
  end

  assign cap_addr      = ptr_q;
  assign cap_wr_ptr    = ptr_q;
  assign cap_trig_addr = trig_q;
  assign cap_busy      = busy_q;
  assign cap_done      = done_q;

endmodule

// File: rtl/ocm_capture_ram.sv
// ---------------------------------------------------------------------------
// ocm_capture_ram
// Dual-port on-chip memory. Port A is an Avalon-MM slave (byte enables,
// clock enable, optional output register); port B is written by the capture
// sequencer so software can read back Rx waveform snapshots.
//
// Ports:
//   clk, reset                    clock, synchronous active-low reset
//   address, byteenable,
//   chipselect, read, write,
//   writedata                     Avalon-MM slave request
//   readdata, readdatavalid       Avalon read response (1 or 2 cycle latency)
//   clken, reset_req              port A enable = clken & ~reset_req
//   cap_arm, cap_abort, cap_mode,
//   cap_post, cap_trigger         capture control
//   cap_valid, cap_data           capture sample stream
//   cap_busy, cap_done,
//   cap_wr_ptr, cap_trig_addr     capture status
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module ocm_capture_ram
  import ocm_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 10,
  parameter int OUT_REG   = 0,
  parameter     INIT_FILE = "onchip_mem.hex"
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W/8-1:0] byteenable,
  input  logic                chipselect,
  input  logic                read,
  input  logic                write,
  input  logic [DATA_W-1:0]   writedata,
  output logic [DATA_W-1:0]   readdata,
  output logic                readdatavalid,
  input  logic                clken,
  input  logic                reset_req,
  input  logic                cap_arm,
  input  logic                cap_abort,
  input  logic                cap_mode,
  input  logic [ADDR_W-1:0]   cap_post,
  input  logic                cap_trigger,
  input  logic                cap_valid,
  input  logic [DATA_W-1:0]   cap_data,
  output logic                cap_busy,
  output logic                cap_done,
  output logic [ADDR_W-1:0]   cap_wr_ptr,
  output logic [ADDR_W-1:0]   cap_trig_addr
);

  localparam int BE_W  = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  logic              en;
  logic              av_rd;
  logic              av_wr;
  logic              collide;
  logic              cap_we;
  logic [ADDR_W-1:0] cap_addr;

  // Initial image is attached by the vendor flow through the RAM attribute.
  (* ram_init_file = INIT_FILE *)
  logic [DATA_W-1:0] mem [DEPTH];

  logic [DATA_W-1:0] rd_p0_q, rd_p0_d;
  logic              vld_p0_q, vld_p0_d;

  assign en = clken & ~reset_req;
  // Same-address collision: the capture word is kept, the Avalon write is
  // dropped for that cycle.
  assign collide = cap_we && (cap_addr == address);
  // A combined read+write request is a write only.
  assign av_rd = en & chipselect & read & ~write;
  assign av_wr = en & chipselect & write & ~collide;

  ocm_capture_ctrl #(
    .ADDR_W (ADDR_W)
  ) u_ctrl (
    .clk           (clk),
    .reset         (reset),
    .cap_arm       (cap_arm),
    .cap_abort     (cap_abort),
    .cap_mode      (cap_mode),
    .cap_post      (cap_post),
    .cap_trigger   (cap_trigger),
    .cap_valid     (cap_valid),
    .cap_we        (cap_we),
    .cap_addr      (cap_addr),
    .cap_busy      (cap_busy),
    .cap_done      (cap_done),
    .cap_wr_ptr    (cap_wr_ptr),
    .cap_trig_addr (cap_trig_addr)
  );

  // Memory array: byte-lane writes on port A, full-word writes on port B.
  always_ff @(posedge clk) begin
    for (int b = 0; b < BE_W; b++) begin
      if (av_wr && byteenable[b]) mem[address][b*8 +: 8] <= writedata[b*8 +: 8];
    end
    if (cap_we) mem[cap_addr] <= cap_data;
  end

  // Stage p0: RAM read register (old data on read-during-write)
  always_comb begin
    rd_p0_d  = rd_p0_q;
    vld_p0_d = vld_p0_q;
    if (en) begin
      vld_p0_d = av_rd;
      if (av_rd) rd_p0_d = mem[address];
    end else if (OUT_REG == 0) begin
      // p0 drives readdatavalid directly, so it must drop while frozen.
      vld_p0_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_p0_q  <= '0;
      vld_p0_q <= 1'b0;
    end else begin
      rd_p0_q  <= rd_p0_d;
      vld_p0_q <= vld_p0_d;
    end
  end

  // Stage p1: optional output register; a pending p0 word waits here
  // across disabled cycles and is delivered on the next enabled edge.
  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_W-1:0] rd_p1_q, rd_p1_d;
    logic              vld_p1_q, vld_p1_d;

    always_comb begin
      rd_p1_d  = rd_p1_q;
      vld_p1_d = 1'b0;
      if (en) begin
        vld_p1_d = vld_p0_q;
        if (vld_p0_q) rd_p1_d = rd_p0_q;
      end
    end

    always_ff @(posedge clk) begin
      if (!reset) begin
        rd_p1_q  <= '0;
        vld_p1_q <= 1'b0;
      end else begin
        rd_p1_q  <= rd_p1_d;
        vld_p1_q <= vld_p1_d;
      end
    end

    assign readdata      = rd_p1_q;
    assign readdatavalid = vld_p1_q;
  end else begin : g_no_out_reg
    assign readdata      = rd_p0_q;
    assign readdatavalid = vld_p0_q;
  end

endmodule
